rgmii_tx_rate_ctrl: RTL
=======================

Name: rgmii_tx_rate_ctrl

Overview:
- GMII-side transmit rate controller for the RGMII PHY interface, clocked by the 125 MHz GTX clock.
- Accepts GMII bytes through a ready handshake and produces DDR pre-output pairs (d1 = rising half, d2 = falling half) for TXC, TXD and TX_CTL.
- The pairs feed the existing oddr instances.
- Generalises the fixed 10/100/1000 scheme:
  - Divisors are parametrised.
  - At 10/100 the block serialises each byte into two nibbles itself.
  - Speed changes are glitch-free, applied only at frame/period boundaries.

Parameters:
- DIV_100M, 5, clk cycles per TXC period at 100M; must be >= 2.
- DIV_10M, 50, clk cycles per TXC period at 10M; must be >= 2.
- CNT_W, 6, period counter width; must satisfy 2^CNT_W >= max(DIV_100M, DIV_10M).

Ports:
- clk  in  1  GTX clock, 125 MHz
- rst  in  1  reset, asynchronous, active-high
- speed  in  2  requested rate: 2'b10 = 1G, 2'b01 = 100M, 2'b00 = 10M; 2'b11 is treated as 1G
- s_txd  in  8  GMII byte
- s_tx_en  in  1  GMII TX_EN
- s_tx_er  in  1  GMII TX_ER
- s_ready  out  1  byte accepted this cycle
- txc_d1, txc_d2  out  1 each  TXC DDR pair
- txd_d1, txd_d2  out  4 each  TXD DDR pair
- txctl_d1, txctl_d2  out  1 each  TX_CTL DDR pair
- tx_clk_en  out  1  one-cycle strobe marking the last cycle of each TXC period
- speed_active  out  2  rate currently in effect

Behaviour:
- Reset (asynchronous) values:
  - txc_d1 = 1, txc_d2 = 0.
  - All txd/txctl outputs = 0.
  - s_ready = 0, tx_clk_en = 0.
  - speed_active = 2'b10; period counter cnt = 0; nibble phase ph = 0; hold register cleared.
  - First cycle after reset release: speed_active takes the value of speed (2'b11 maps to 2'b10).
- 1G mode:
  - s_ready = 1 and tx_clk_en = 1 every cycle; txc_d1 = 1, txc_d2 = 0.
  - Byte accepted in cycle k appears at cycle k+1 as:
    - txd_d1 = s_txd[3:0], txd_d2 = s_txd[7:4].
    - txctl_d1 = en, txctl_d2 = en ^ er.
- 10/100 mode, with N = the active divisor:
  - cnt counts 0..N-1 and wraps.
  - Half-cycle index is h = 2*cnt (d1) or 2*cnt+1 (d2); TXC = 1 when h < N, else 0.
    - N = 5 gives (1,1),(1,1),(1,0),(0,0),(0,0).
    - N = 50 gives TXC high for cnt 0..24.
  - tx_clk_en = 1 only when cnt == N-1.
  - Each byte occupies two TXC periods: ph = 0 carries the low nibble, ph = 1 the high nibble. ph toggles when cnt == N-1.
  - s_ready = 1 only when cnt == N-1 and ph == 1. The byte is captured into the hold register.
  - The hold register is reset-initialised, so the first s_ready can occur before any byte has been captured.
  - Byte accepted in cycle k: low nibble is driven on both txd_d1 and txd_d2 during cycles k+1..k+N; high nibble during k+N+1..k+2N.
  - TX_CTL per period: txctl_d1 = txctl_d2 = en while TXC is high, and en ^ er while TXC is low. For the mixed cnt: d1 = en, d2 = en ^ er.
  - Idle bytes (en = 0) also consume two periods.
- Speed switching:
  - A change request (speed != speed_active) is applied only at a byte boundary where:
    - s_ready is high, and
    - hold-register en == 0, and
    - s_tx_en == 0.
  - Such a boundary is every cycle in 1G mode, or cnt == N-1 with ph == 1 in 10/100 mode.
  - On switch: next cycle speed_active is updated, cnt = 0, ph = 0, TXC restarts high.
  - A request during a frame is deferred until the frame ends. A request withdrawn before the boundary is ignored.
  - speed changing while a frame is in progress never truncates a TXC period or a byte.
- Mid-frame reset: all outputs return to reset values immediately; no partial-nibble completion.

Optional Feature:
- RGMII_TX_STATS_EN, when defined, adds two outputs:
  - stat_frames (32 bits): increments on each accepted byte with en = 1 whose predecessor had en = 0.
  - stat_errs (16 bits): increments on each accepted byte with en = 1 and er = 1; saturates at 16'hFFFF.
  - Both are cleared by rst.
- When undefined: the ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package rgmii_pkg:
  - SPEED_10M / SPEED_100M / SPEED_1G localparam constants.
  - Function mapping speed to divisor.
- Sub-module rgmii_txc_gen: contains cnt, the TXC d1/d2 pattern and tx_clk_en, driven by divisor N and a restart input.
- Top level holds: hold register, nibble phase, handshake, speed-switch arbitration, and the optional stats.

Test Plan:
- 1G, bytes 0xA5,0x3C with en=1, er=0 → next cycles txd_d1/d2 = 5/A then C/3; txctl = 1/1; s_ready always 1.
- 100M (N=5), byte 0xD5 with en=1:
  - txd = 5 for 5 cycles, then D for 5 cycles.
  - txc pattern (1,1),(1,1),(1,0),(0,0),(0,0).
  - s_ready pulses every 10 cycles; tx_clk_en every 5 cycles.
- 10M (N=50), en=1, er=1 → txctl = 1 for cnt 0..24 and 0 for cnt 25..49; tx_clk_en every 50 cycles.
- Speed 1G→100M requested mid-frame → speed_active stays 2'b10 until the first boundary with en=0 on both held and incoming byte, then switches with cnt=0.
- Assert rst at cnt=3, ph=1 in 100M → outputs immediately at reset values; after release, speed_active = speed and TXC restarts high.
- RGMII_TX_STATS_EN defined, two 64-byte frames, the second with one er byte → stat_frames = 2, stat_errs = 1.

Source files
------------

// File: rtl/rgmii_pkg.sv
// rtl/rgmii_pkg.sv - shared constants, types and helpers for the RGMII TX rate controller
//
// Purpose: speed encodings, the held GMII byte type and the speed-to-divisor
// mapping used by rgmii_tx_rate_ctrl and rgmii_txc_gen.
package rgmii_pkg;

  localparam logic [1:0] SPEED_10M  = 2'b00;
  localparam logic [1:0] SPEED_100M = 2'b01;
  localparam logic [1:0] SPEED_1G   = 2'b10;

  // One GMII transfer as captured into the hold register.
  typedef struct packed {
    logic       en;
    logic       er;
    logic [7:0] d;
  } gmii_byte_t;

  // 2'b11 is not a real rate; it runs as 1G.
  function automatic logic [1:0] norm_speed(input logic [1:0] s);
    return (s == 2'b11) ? SPEED_1G : s;
  endfunction

  // clk cycles per TXC period; 1G runs one period per clk.
  function automatic int speed_div(input logic [1:0] s, input int d100, input int d10);
    case (s)
      SPEED_10M:  return d10;
      SPEED_100M: return d100;
      default:    return 1;
    endcase
  endfunction

endpackage

// File: rtl/rgmii_tx_rate_ctrl_if.sv
// rtl/rgmii_tx_rate_ctrl_if.sv - GMII byte handshake between the MAC and the rate controller
//
// Signals:
//   txd    8  GMII byte
//   tx_en  1  GMII TX_EN
//   tx_er  1  GMII TX_ER
//   ready  1  byte accepted this cycle (driven by the rate controller)
// Modports: master = byte source, slave = rate controller.
interface rgmii_tx_rate_ctrl_if;
  logic [7:0] txd;
  logic       tx_en;
  logic       tx_er;
  logic       ready;

  modport master (output txd, output tx_en, output tx_er, input ready);
  modport slave  (input txd, input tx_en, input tx_er, output ready);
endinterface

// File: rtl/rgmii_txc_gen.sv
// rtl/rgmii_txc_gen.sv - TXC period counter and DDR clock pattern generator
//
// Ports:
//   clk, rst        GTX clock, asynchronous active-high reset
//   div             clk cycles per TXC period (ignored when fast)
//   fast            1G mode: one TXC period per clk, pattern 1/0
//   active          gates tx_clk_en (low until the first cycle after reset)
//   restart         force cnt back to 0 so the next period starts high
//   last            current cycle is the last of a TXC period
//   txc_d1, txc_d2  TXC rising/falling half values
//   tx_clk_en       last, qualified by active
module rgmii_txc_gen #(
  parameter int CNT_W = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [CNT_W:0] div,
  input  logic           fast,
  input  logic           active,
  input  logic           restart,
  output logic           last,
  output logic           txc_d1,
  output logic           txc_d2,
  output logic           tx_clk_en
);

  logic [CNT_W-1:0] cnt;

  assign last      = fast | ({1'b0, cnt} == (div - (CNT_W + 1)'(1)));
  assign tx_clk_en = active & last;

  // Half-cycle index h is 2*cnt on the rising half and 2*cnt+1 on the
  // falling half; TXC is high for the first div half-cycles of the period.
  assign txc_d1 = fast | ({cnt, 1'b0} < div);
  assign txc_d2 = ~fast & ({cnt, 1'b1} < div);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rgmii_tx_rate_ctrl.sv
// rtl/rgmii_tx_rate_ctrl.sv - GMII to RGMII DDR pre-output rate controller (10/100/1000)
//
// Optional feature macro: RGMII_TX_STATS_EN (adds stat_frames / stat_errs).
//
// Ports:
//   clk, rst              GTX clock 125 MHz, asynchronous active-high reset
//   speed                 requested rate (00 10M, 01 100M, 10/11 1G)
//   s                     GMII byte handshake (slave side)
//   txc_d1, txc_d2        TXC DDR pair
//   txd_d1, txd_d2        TXD DDR pair
//   txctl_d1, txctl_d2    TX_CTL DDR pair
//   tx_clk_en             strobe on the last cycle of each TXC period
//   speed_active          rate currently in effect
//   stat_frames           frames started (RGMII_TX_STATS_EN only)
//   stat_errs             bytes sent with TX_ER, saturating (RGMII_TX_STATS_EN only)
module rgmii_tx_rate_ctrl
  import rgmii_pkg::*;
#(
  parameter int DIV_100M = 5,
  parameter int DIV_10M  = 50,
  parameter int CNT_W    = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] speed,
  rgmii_tx_rate_ctrl_if.slave s,
  output logic       txc_d1,
  output logic       txc_d2,
  output logic [3:0] txd_d1,
  output logic [3:0] txd_d2,
  output logic       txctl_d1,
  output logic       txctl_d2,
  output logic       tx_clk_en,
  output logic [1:0] speed_active
`ifdef RGMII_TX_STATS_EN
  ,
  output logic [31:0] stat_frames,
  output logic [15:0] stat_errs
`endif
);

  logic           started;  // low from reset until the first edge after release
  logic           ph;       // 0: low nibble period, 1: high nibble period
  gmii_byte_t     hold;
  gmii_byte_t     incoming;
  logic [1:0]     speed_req;
  logic           fast;
  logic [CNT_W:0] div;
  logic           last;
  logic           boundary;
  logic           do_switch;
  logic           restart;
  logic [3:0]     nib;

  assign incoming  = '{en: s.tx_en, er: s.tx_er, d: s.txd};
  assign speed_req = norm_speed(speed);
  assign fast      = (speed_active == SPEED_1G);
  assign div       = (CNT_W + 1)'(speed_div(speed_active, DIV_100M, DIV_10M));

  // A byte boundary is the cycle a new byte is taken: every cycle at 1G,
  // end of the high-nibble period at 10/100.
  assign boundary = started & last & (fast | ph);
  assign s.ready  = boundary;

  // Rate changes only between frames: neither the byte on the wire nor the
  // one being taken may belong to a frame.
  assign do_switch = boundary & ~hold.en & ~s.tx_en & (speed_req != speed_active);
  assign restart   = ~started | do_switch;

  rgmii_txc_gen #(.CNT_W(CNT_W)) u_txc_gen (
    .clk       (clk),
    .rst       (rst),
    .div       (div),
    .fast      (fast),
    .active    (started),
    .restart   (restart),
    .last      (last),
    .txc_d1    (txc_d1),
    .txc_d2    (txc_d2),
    .tx_clk_en (tx_clk_en)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      started      <= 1'b0;
      speed_active <= SPEED_1G;
      ph           <= 1'b0;
      hold         <= '0;
    end else begin
      started <= 1'b1;
      if (restart) begin
        speed_active <= speed_req;
        ph           <= 1'b0;
      end else if (!fast && last) begin
        ph <= ~ph;
      end
      if (boundary) begin
        hold <= incoming;
      end
    end
  end

  // At 10/100 the same nibble goes out on both halves for a whole period.
  assign nib = ph ? hold.d[7:4] : hold.d[3:0];

  always_comb begin
    txd_d1 = nib;
    txd_d2 = nib;
    if (fast) begin
      txd_d1 = hold.d[3:0];
      txd_d2 = hold.d[7:4];
    end
  end

  // TX_CTL carries EN while TXC is high and EN^ER while it is low; at 1G
  // the 1/0 TXC pattern makes this the usual d1 = EN, d2 = EN^ER.
  assign txctl_d1 = txc_d1 ? hold.en : (hold.en ^ hold.er);
  assign txctl_d2 = txc_d2 ? hold.en : (hold.en ^ hold.er);

`ifdef RGMII_TX_STATS_EN
  // hold still holds the previously accepted byte, i.e. the predecessor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_frames <= '0;
      stat_errs   <= '0;
    end else if (boundary && s.tx_en) begin
      if (!hold.en) begin
        stat_frames <= stat_frames + 32'd1;
      end
      if (s.tx_er && (stat_errs != 16'hFFFF)) begin
        stat_errs <= stat_errs + 16'd1;
      end
    end
  end
`endif

endmodule
